// File: rtl/round_controller.sv
// Mastermind round sequencer: turns touch events into guess edits and submits,
// handshakes with the peg scorer, holds the result, then steps rows until win or loss.
module round_controller #(
    parameter int ROWS        = 8,
    parameter int TOUCH_GAP   = 15000000,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        touch_valid,
    input  logic [2:0]  touch_col,
    input  logic        score_ack,
    input  logic [2:0]  score_black,
    input  logic [2:0]  score_white,
    output logic        score_req,
    output logic [11:0] guess,
    output logic [2:0]  row,
    output logic [2:0]  black_pegs,
    output logic [2:0]  white_pegs,
    output logic        next_round,
    output logic        game_won,
    output logic        game_lost,
    output logic [7:0]  col_led
);

    localparam int GAP_W  = (TOUCH_GAP < 1) ? 1 : $clog2(TOUCH_GAP + 1);
    localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(TOUCH_GAP);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]        ROW_TOP   = 3'(ROWS - 1);

    typedef enum logic [2:0] {
        ST_EDIT  = 3'd0,
        ST_SCORE = 3'd1,
        ST_HOLD  = 3'd2,
        ST_WON   = 3'd3,
        ST_LOST  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         row_q, row_d;
    logic [11:0]        guess_q, guess_d;
    logic [2:0]         black_q, black_d;
    logic [2:0]         white_q, white_d;
    logic [7:0]         col_led_q, col_led_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               score_req_q, score_req_d;
    logic               next_round_q, next_round_d;
    logic               game_won_q, game_won_d;
    logic               game_lost_q, game_lost_d;

    logic               touch_ok_s;
    logic [2:0]         blk_s;
    logic [2:0]         wht_lim_s;
    logic [2:0]         wht_s;

    // Colour cycle 1..6; an empty field starts at 1.
    function automatic logic [2:0] next_colour(input logic [2:0] f);
        if ((f == 3'd0) || (f >= 3'd6)) begin
            return 3'd1;
        end else begin
            return f + 3'd1;
        end
    endfunction

    function automatic logic all_set(input logic [11:0] g);
        return (g[2:0] != 3'd0) && (g[5:3] != 3'd0) &&
               (g[8:6] != 3'd0) && (g[11:9] != 3'd0);
    endfunction

    assign touch_ok_s = touch_valid && (gap_q == '0) && (touch_col <= 3'd4);
    assign blk_s      = (score_black > 3'd4) ? 3'd4 : score_black;
    assign wht_lim_s  = 3'd4 - blk_s;
    assign wht_s      = (score_white > wht_lim_s) ? wht_lim_s : score_white;

    // Next-state and next-output computation for the round FSM.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        guess_d      = guess_q;
        black_d      = black_q;
        white_d      = white_q;
        col_led_d    = col_led_q;
        hold_d       = hold_q;
        score_req_d  = score_req_q;
        next_round_d = next_round_q;
        game_won_d   = game_won_q;
        game_lost_d  = game_lost_q;
        if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end else begin
            gap_d = '0;
        end

        case (state_q)
            ST_EDIT: begin
                if (touch_ok_s && (touch_col != 3'd4)) begin
                    guess_d[3*touch_col[1:0] +: 3] = next_colour(guess_q[3*touch_col[1:0] +: 3]);
                    col_led_d = 8'd1 << touch_col[1:0];
                    gap_d     = GAP_LOAD;
                end else if (touch_ok_s && all_set(guess_q)) begin
                    state_d     = ST_SCORE;
                    score_req_d = 1'b1;
                    gap_d       = GAP_LOAD;
                end else begin
                    state_d = ST_EDIT;
                end
            end
            ST_SCORE: begin
                if (score_ack) begin
                    black_d     = blk_s;
                    white_d     = wht_s;
                    score_req_d = 1'b0;
                    if (blk_s == 3'd4) begin
                        state_d    = ST_WON;
                        game_won_d = 1'b1;
                        col_led_d  = 8'hFF;
                    end else if (row_q == 3'd0) begin
                        state_d     = ST_LOST;
                        game_lost_d = 1'b1;
                        col_led_d   = 8'h0F;
                    end else begin
                        state_d      = ST_HOLD;
                        next_round_d = 1'b1;
                        col_led_d    = 8'h0F;
                        hold_d       = HOLD_LOAD;
                    end
                end else begin
                    state_d = ST_SCORE;
                end
            end
            ST_HOLD: begin
                // Row only decrements from here, and HOLD is only entered with row > 0.
                if (hold_q == '0) begin
                    state_d      = ST_EDIT;
                    row_d        = row_q - 3'd1;
                    guess_d      = 12'd0;
                    black_d      = 3'd0;
                    white_d      = 3'd0;
                    gap_d        = '0;
                    next_round_d = 1'b0;
                    col_led_d    = 8'h00;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_WON: begin
                state_d = ST_WON;
            end
            ST_LOST: begin
                state_d = ST_LOST;
            end
            default: begin
                state_d = ST_EDIT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_EDIT;
            row_q        <= ROW_TOP;
            guess_q      <= 12'd0;
            black_q      <= 3'd0;
            white_q      <= 3'd0;
            col_led_q    <= 8'h00;
            gap_q        <= '0;
            hold_q       <= '0;
            score_req_q  <= 1'b0;
            next_round_q <= 1'b0;
            game_won_q   <= 1'b0;
            game_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            guess_q      <= guess_d;
            black_q      <= black_d;
            white_q      <= white_d;
            col_led_q    <= col_led_d;
            gap_q        <= gap_d;
            hold_q       <= hold_d;
            score_req_q  <= score_req_d;
            next_round_q <= next_round_d;
            game_won_q   <= game_won_d;
            game_lost_q  <= game_lost_d;
        end
    end

    assign score_req  = score_req_q;
    assign guess      = guess_q;
    assign row        = row_q;
    assign black_pegs = black_q;
    assign white_pegs = white_q;
    assign next_round = next_round_q;
    assign game_won   = game_won_q;
    assign game_lost  = game_lost_q;
    assign col_led    = col_led_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: vector table for guess editing,
// hand-written sequences for the scorer handshake, hold timing and end states.
module tb_round_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        touch_valid = 1'b0;
    logic [2:0]  touch_col = 3'd0;
    logic        score_ack = 1'b0;
    logic [2:0]  score_black = 3'd0;
    logic [2:0]  score_white = 3'd0;
    logic        score_req;
    logic [11:0] guess;
    logic [2:0]  row;
    logic [2:0]  black_pegs;
    logic [2:0]  white_pegs;
    logic        next_round;
    logic        game_won;
    logic        game_lost;
    logic [7:0]  col_led;

    int checks = 0;
    int errors = 0;

    round_controller #(.ROWS(8), .TOUCH_GAP(2), .HOLD_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .touch_valid(touch_valid), .touch_col(touch_col),
        .score_ack(score_ack), .score_black(score_black), .score_white(score_white),
        .score_req(score_req), .guess(guess), .row(row), .black_pegs(black_pegs),
        .white_pegs(white_pegs), .next_round(next_round), .game_won(game_won),
        .game_lost(game_lost), .col_led(col_led)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  col;
        int          idle;
        logic [11:0] exp_guess;
        logic [7:0]  exp_led;
        logic        exp_req;
    } vec_t;

    typedef struct {
        logic [11:0] g;
        logic [7:0]  l;
        logic        r;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic [2:0] c, input int idl, input logic [11:0] g,
                                input logic [7:0] l, input logic r);
        vec_t v;
        v.col = c; v.idle = idl; v.exp_guess = g; v.exp_led = l; v.exp_req = r;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic touch(input logic [2:0] c);
        touch_valid = 1'b1;
        touch_col   = c;
        tick();
        touch_valid = 1'b0;
        touch_col   = 3'd0;
    endtask

    task automatic fill_all();
        for (int c = 0; c < 4; c++) begin
            touch(3'(c));
            tick(); tick();
        end
    endtask

    task automatic play_round(input logic [2:0] b, input logic [2:0] w);
        fill_all();
        touch(3'd4);
        chk("round_req_up", 32'(score_req), 32'd1);
        score_ack = 1'b1; score_black = b; score_white = w;
        tick();
        score_ack = 1'b0; score_black = 3'd0; score_white = 3'd0;
        chk("round_req_down", 32'(score_req), 32'd0);
    endtask

    task automatic wait_hold_end();
        int i;
        for (i = 0; i < 20; i++) begin
            if (!next_round) break;
            tick();
        end
        if (i == 20) begin
            errors++;
            $display("FAIL hold_timeout: next_round still %0d after 20 cycles, expected 0", next_round);
        end
    endtask

    initial begin
        exp_t e;
        vec_t v;
        int   cnt;
        logic [11:0] g_seen;

        for (int k = 0; k < 7; k++) begin
            vecs.push_back(mk(3'd0, 2, 12'((k % 6) + 1), 8'h01, 1'b0));
        end
        vecs.push_back(mk(3'd5, 2, 12'h001, 8'h01, 1'b0));
        vecs.push_back(mk(3'd1, 0, 12'h009, 8'h02, 1'b0));
        vecs.push_back(mk(3'd1, 1, 12'h009, 8'h02, 1'b0));
        vecs.push_back(mk(3'd1, 2, 12'h011, 8'h02, 1'b0));
        vecs.push_back(mk(3'd2, 2, 12'h051, 8'h04, 1'b0));
        vecs.push_back(mk(3'd2, 2, 12'h091, 8'h04, 1'b0));
        vecs.push_back(mk(3'd2, 2, 12'h0D1, 8'h04, 1'b0));
        vecs.push_back(mk(3'd4, 0, 12'h0D1, 8'h04, 1'b0));
        vecs.push_back(mk(3'd3, 2, 12'h2D1, 8'h08, 1'b0));
        vecs.push_back(mk(3'd3, 2, 12'h4D1, 8'h08, 1'b0));
        vecs.push_back(mk(3'd3, 2, 12'h6D1, 8'h08, 1'b0));
        vecs.push_back(mk(3'd3, 2, 12'h8D1, 8'h08, 1'b0));
        vecs.push_back(mk(3'd4, 0, 12'h8D1, 8'h08, 1'b1));

        // Reset state
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("rst_row", 32'(row), 32'd7);
        chk("rst_guess", 32'(guess), 32'd0);
        chk("rst_black", 32'(black_pegs), 32'd0);
        chk("rst_white", 32'(white_pegs), 32'd0);
        chk("rst_req", 32'(score_req), 32'd0);
        chk("rst_led", 32'(col_led), 32'd0);
        chk("rst_flags", 32'({game_won, game_lost, next_round}), 32'd0);

        // Table-driven edit sequence through to an accepted submit
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            e.g = v.exp_guess; e.l = v.exp_led; e.r = v.exp_req;
            sb.push_back(e);
            touch(v.col);
            e = sb.pop_front();
            chk($sformatf("vec%0d_guess", i), 32'(guess), 32'(e.g));
            chk($sformatf("vec%0d_led", i), 32'(col_led), 32'(e.l));
            chk($sformatf("vec%0d_req", i), 32'(score_req), 32'(e.r));
            for (int j = 0; j < v.idle; j++) tick();
        end

        // Normal round: ack arrives 3 cycles after submit
        tick(); tick();
        chk("req_held", 32'(score_req), 32'd1);
        score_ack = 1'b1; score_black = 3'd1; score_white = 3'd2;
        tick();
        score_ack = 1'b0; score_black = 3'd0; score_white = 3'd0;
        chk("n_req_down", 32'(score_req), 32'd0);
        chk("n_black", 32'(black_pegs), 32'd1);
        chk("n_white", 32'(white_pegs), 32'd2);
        chk("n_led", 32'(col_led), 32'h0F);
        chk("n_guess_frozen", 32'(guess), 32'h8D1);
        cnt = next_round ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            if (!next_round) break;
            tick();
            if (next_round) cnt++;
        end
        chk("hold_len", 32'(cnt), 32'd4);
        chk("after_row", 32'(row), 32'd6);
        chk("after_guess", 32'(guess), 32'd0);
        chk("after_pegs", 32'({black_pegs, white_pegs}), 32'd0);
        chk("after_nr", 32'(next_round), 32'd0);

        // Minimum handshake plus white clamp
        play_round(3'd3, 3'd3);
        chk("clamp_black", 32'(black_pegs), 32'd3);
        chk("clamp_white", 32'(white_pegs), 32'd1);
        chk("clamp_nr", 32'(next_round), 32'd1);
        wait_hold_end();
        chk("row5", 32'(row), 32'd5);

        // Win
        play_round(3'd4, 3'd2);
        chk("won_flag", 32'(game_won), 32'd1);
        chk("won_led", 32'(col_led), 32'hFF);
        chk("won_pegs", 32'({black_pegs, white_pegs}), 32'({3'd4, 3'd0}));
        chk("won_nr", 32'(next_round), 32'd0);
        g_seen = 12'h249;
        chk("won_guess", 32'(guess), 32'(g_seen));
        touch(3'd0); tick(); tick();
        touch(3'd4); tick(); tick();
        chk("won_guess_frozen", 32'(guess), 32'(g_seen));
        chk("won_row_frozen", 32'(row), 32'd5);
        chk("won_req", 32'(score_req), 32'd0);

        // Reset dropped mid-handshake
        reset = 1'b0; tick(); reset = 1'b1; tick();
        fill_all();
        touch(3'd4);
        chk("mid_req_up", 32'(score_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_req_drop", 32'(score_req), 32'd0);
        chk("mid_won_clear", 32'(game_won), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Play to row 0 and lose
        for (int r = 7; r >= 1; r--) begin
            play_round(3'd0, 3'd0);
            wait_hold_end();
            chk($sformatf("row_step%0d", r), 32'(row), 32'(r - 1));
        end
        play_round(3'd3, 3'd2);
        chk("lost_flag", 32'(game_lost), 32'd1);
        chk("lost_nr", 32'(next_round), 32'd0);
        chk("lost_led", 32'(col_led), 32'h0F);
        chk("lost_pegs", 32'({black_pegs, white_pegs}), 32'({3'd3, 3'd1}));
        for (int i = 0; i < 6; i++) tick();
        chk("lost_nr_stays", 32'(next_round), 32'd0);
        chk("lost_row", 32'(row), 32'd0);
        chk("lost_sticky", 32'({game_lost, game_won}), 32'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/round_controller.md
# round_controller

Sequencer for one Mastermind game. It turns decoded touch events into guess edits and submits, and drives a req/ack handshake to the peg scorer. It also times the post-score display hold, steps the active row, and detects win or loss. It sits between the touch coordinate decoder, the scorer and the display/LED logic.

## Interface

Parameters:
- `ROWS`, default 8: rows per game; play starts at row `ROWS-1`.
- `TOUCH_GAP`, default 15000000: cycles after an accepted touch during which `touch_valid` is ignored.
- `HOLD_CYCLES`, default 25000000: cycles a scored result is held before the next row.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `touch_valid`  in  1  one-cycle pulse, decoded touch present.
- `touch_col`  in  3  0–3 = peg column, 4 = submit, 5–7 = ignored.
- `score_ack`  in  1  scorer result valid; sampled only while `score_req`=1.
- `score_black`  in  3  exact-position matches.
- `score_white`  in  3  colour-only matches.
- `score_req`  out  1  request scoring of `guess`.
- `guess`  out  12  four 3-bit colour fields, col0 at [2:0] … col3 at [11:9]; 0 = empty, 1–6 = colours.
- `row`  out  3  active row index.
- `black_pegs`  out  3  latched black result.
- `white_pegs`  out  3  latched white result.
- `next_round`  out  1  high during hold.
- `game_won`  out  1  sticky win flag.
- `game_lost`  out  1  sticky loss flag.
- `col_led`  out  8  status LEDs.

## Operation

States: EDIT, SCORE, HOLD, WON, LOST.

**Reset state**
- State = EDIT, `row`=`ROWS-1`.
- `guess`, `black_pegs`, `white_pegs`, `col_led`, the gap counter and every 1-bit output are 0.

**EDIT**
- A touch is accepted when `touch_valid`=1, the gap counter is 0 and `touch_col` ≤ 4.
- Accepted column touch c:
  - field c increments; 0→1, 6→1.
  - `col_led` = one-hot bit c.
  - gap counter loads `TOUCH_GAP`.
- Accepted submit with all four fields nonzero: go to SCORE and load the gap counter.
- Submit with any field zero is ignored and does not load the gap counter.
- `touch_col` 5–7 is ignored.
- The gap counter decrements to 0 every cycle. Touches during the gap are dropped, not queued.

**SCORE**
- `score_req`=1 until `score_ack` is sampled high.
- On ack, latch the results:
  - black = min(`score_black`, 4);
  - white = min(`score_white`, 4 − black).
- Next state:
  - black==4 → WON;
  - else `row`==0 → LOST;
  - else → HOLD.
- `guess` is frozen in SCORE; touches are ignored.

**HOLD**
- `next_round`=1 and `col_led`=8'h0F for `HOLD_CYCLES` cycles.
- Then in one edge: `row` decrements, `guess` and both peg outputs clear, the gap counter clears, `next_round`=0, go to EDIT.

**WON / LOST**
- Terminal until reset; all touches are ignored.
- WON: `game_won`=1, `col_led`=8'hFF.
- LOST: `game_lost`=1, `col_led`=8'h0F.
- `guess`, `row` and the pegs stay frozen.

**Input handling**
- `score_ack` outside SCORE is ignored.

## Timing

- All outputs are registered. An accepted touch at edge N shows on `guess`/`col_led` after edge N.
- Submit accepted at edge N → `score_req` high from after edge N.
- Ack sampled at edge M → after edge M:
  - `score_req`=0;
  - pegs valid;
  - state HOLD/WON/LOST, with `next_round`, `game_won` or `game_lost` already high.
- An ack in the same cycle `score_req` first rises is accepted, giving a minimum 1-cycle handshake.
- `next_round` is high for exactly `HOLD_CYCLES` cycles. The counter width must hold `HOLD_CYCLES`.
- The gap counter blocks exactly `TOUCH_GAP` cycles after the accepting edge. A touch on cycle `TOUCH_GAP+1` is accepted.
- Reset asserted mid-handshake drops `score_req` immediately. The scorer must tolerate an abandoned request.
- `row` never wraps: decrement happens only from HOLD, which requires `row` > 0.

## Test plan

Bench parameters: `ROWS`=8, `TOUCH_GAP`=2, `HOLD_CYCLES`=4.

- **Reset:** release reset → `row`=7, `guess`=0, pegs 0, `score_req`=0, `col_led`=0, both flags 0.
- **Colour wrap:** seven col0 touches spaced 3 cycles → `guess[2:0]` steps 1,2,3,4,5,6,1; `col_led`=8'h01.
- **Gap filter:** col1 touch, then col1 touch 1 cycle later → `guess[5:3]`=1. A col1 touch 3 cycles after the first → `guess[5:3]`=2.
- **Incomplete submit:** fields 1,2,3,0, submit → `score_req` stays 0, state EDIT. A col3 touch on the next cycle is accepted (gap not loaded).
- **Normal round:** fields 1,2,3,4, submit, ack 3 cycles later with black=1, white=2 →
  - pegs 1/2 the cycle after ack;
  - `next_round` high 4 cycles;
  - then `row`=6, `guess`=0, pegs 0.
  - Ack with black=3, white=3 → white latched as 1.
- **End states:**
  - Ack black=4 → `game_won`=1, `col_led`=8'hFF; later touches leave `guess` unchanged.
  - Separately, reach `row`=0 and ack black=3 → `game_lost`=1, `next_round` stays 0, `row` stays 0.
